// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder slice.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [31:0] BUS_ERR_DATA = 32'hBAD0_BAD0;

   // An access is rejected when misaligned or beyond the word array.
   function automatic logic addr_is_bad(input logic [31:0] addr, input int addr_bits);
      return (addr[1:0] != 2'b00) || ((addr >> (addr_bits + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/response bus between memcontrol (master) and the responder (slave).
interface mem_bus_responder_if;

   logic        read_req;
   logic        write_req;
   logic [31:0] address_in;
   logic [31:0] data_in;
   logic [3:0]  byte_sel;
   logic        bus_full;
   logic [31:0] data_out;
   logic        data_valid;
   logic        error;

   modport master (
      output read_req, write_req, address_in, data_in, byte_sel,
      input  bus_full, data_out, data_valid, error
   );

   modport slave (
      input  read_req, write_req, address_in, data_in, byte_sel,
      output bus_full, data_out, data_valid, error
   );

endinterface

// File: rtl/mem_bus_sram.sv
// Word array with per-byte write enables and a registered read port.
module mem_bus_sram #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [3:0]           be,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [31:0]          wdata,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [31:0]          rd_data
);

   logic [31:0] mem_q [2**ADDR_BITS];
   logic [31:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rd_data_q <= mem_q[raddr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Fixed-latency memory responder: accepts one access at a time, answers with a one-cycle strobe.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic                clk,
   input  logic                rst,
   mem_bus_responder_if.slave  bus
);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  sel_q, sel_d;
   logic        is_read_q, is_read_d;
   logic        bus_full_q, bus_full_d;
   logic        data_valid_q, data_valid_d;
   logic        error_q, error_d;
   logic [31:0] data_out_q, data_out_d;

   logic                 commit;
   logic                 bad_addr;
   logic                 mem_we;
   logic [ADDR_BITS-1:0] rd_addr;
   logic [31:0]          rd_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         sel_q        <= 4'd0;
         is_read_q    <= 1'b0;
         bus_full_q   <= 1'b0;
         data_valid_q <= 1'b0;
         error_q      <= 1'b0;
         data_out_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         sel_q        <= sel_d;
         is_read_q    <= is_read_d;
         bus_full_q   <= bus_full_d;
         data_valid_q <= data_valid_d;
         error_q      <= error_d;
         data_out_q   <= data_out_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      sel_d     = sel_q;
      is_read_d = is_read_q;
      case (state_q)
         IDLE: begin
            if (bus.read_req || bus.write_req) begin
               state_d   = BUSY;
               cnt_d     = 4'(LATENCY - 1);
               addr_d    = bus.address_in;
               wdata_d   = bus.data_in;
               sel_d     = bus.byte_sel;
               is_read_d = bus.read_req;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The read port follows the live address while idle so the word is ready even at LATENCY=1.
   always_comb begin
      commit       = (state_q == BUSY) && (cnt_q == 4'd0);
      bad_addr     = addr_is_bad(addr_q, ADDR_BITS);
      mem_we       = commit && !is_read_q && !bad_addr && !rst;
      rd_addr      = (state_q == IDLE) ? bus.address_in[ADDR_BITS+1:2] : addr_q[ADDR_BITS+1:2];
      bus_full_d   = (state_d != IDLE);
      data_valid_d = commit;
      error_d      = commit && bad_addr;
      data_out_d   = data_out_q;
      if (commit) begin
         if (bad_addr)       data_out_d = BUS_ERR_DATA;
         else if (is_read_q) data_out_d = rd_data;
      end
   end

   mem_bus_sram #(
      .ADDR_BITS(ADDR_BITS)
   ) u_sram (
      .clk    (clk),
      .we     (mem_we),
      .be     (sel_q),
      .waddr  (addr_q[ADDR_BITS+1:2]),
      .wdata  (wdata_q),
      .raddr  (rd_addr),
      .rd_data(rd_data)
   );

   assign bus.bus_full   = bus_full_q;
   assign bus.data_valid = data_valid_q;
   assign bus.error      = error_q;
   assign bus.data_out   = data_out_q;

endmodule
